// File: rtl/capture_wr_ctrl.sv
// Packet-capture write controller: writes a 4-word record header
// (seconds, nanoseconds, len, len) and then the packet payload drained from a
// show-ahead FIFO into a circular capture buffer through an Avalon-MM burst
// write master. Bursts never cross the buffer wrap point.
module capture_wr_ctrl #(
  parameter int MAX_BURST = 16,
  parameter int USEDW_W   = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_ctrl,
  input  logic               empty,
  input  logic [31:0]        control,
  input  logic [31:0]        pkt_begin,
  input  logic [31:0]        pkt_end,
  input  logic [31:0]        capt_buf_start,
  input  logic [31:0]        capt_buf_size,
  input  logic [31:0]        last_write_addr_in,
  input  logic [31:0]        fifo_out,
  output logic               rd_from_fifo,
  output logic               wr_ctrl_rdy,
  output logic [31:0]        last_write_addr_out,
  output logic               capt_buf_wrap,
  input  logic [USEDW_W-1:0] usedw,
  input  logic [31:0]        seconds,
  input  logic [31:0]        nanoseconds,
  output logic [31:0]        address,
  output logic [31:0]        writedata,
  output logic               write,
  output logic [15:0]        burstcount,
  input  logic               waitrequest
);

  localparam logic [31:0] MAX_B = 32'(MAX_BURST);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    HDR_BURST,
    WAIT_DATA,
    DATA_BURST,
    DONE
  } state_t;

  state_t      state, state_next;

  // Record context captured when a request is accepted.
  logic [31:0] sec_q, ns_q, len_q;
  logic [31:0] buf_start_q, buf_end_q;

  // Progress through the record.
  logic [31:0] cur_addr;     // byte address of the next word to write
  logic [31:0] data_left;    // payload words still to write
  logic [2:0]  hdr_left;     // header words still to write (4..0)
  logic [31:0] beats_left;   // beats remaining in the current burst

  logic [31:0] len_calc, words_calc;
  logic [31:0] room, remain, burst_len;
  logic [31:0] addr_inc, next_addr;
  logic [31:0] hdr_word;
  logic        wrap_hit, accept, data_ready, start_burst;

  // The reserved control word has no function in this block.
  logic        unused_control;
  assign unused_control = ^control;

  // Packet length in bytes, clamped to zero for a reversed range, and its
  // size in words rounded up.
  assign len_calc   = (pkt_end >= pkt_begin) ? (pkt_end - pkt_begin) : 32'd0;
  assign words_calc = (len_calc >> 2) + {31'd0, |len_calc[1:0]};

  // Words left before the wrap point, and words left in the current phase.
  assign room   = (buf_end_q - cur_addr) >> 2;
  assign remain = (state == HDR_BURST) ? {29'd0, hdr_left} : data_left;

  // Burst length: smallest of the master limit, the phase remainder and the
  // distance to the wrap point.
  always_comb begin
    burst_len = MAX_B;
    if (remain < burst_len) burst_len = remain;
    if (room < burst_len)   burst_len = room;
  end

  assign addr_inc   = cur_addr + 32'd4;
  assign wrap_hit   = (addr_inc == buf_end_q);
  assign next_addr  = wrap_hit ? buf_start_q : addr_inc;

  assign accept     = write && !waitrequest;
  assign data_ready = (32'(usedw) >= burst_len) && !empty;

  // Header word selected by how many header words remain to be written.
  always_comb begin
    case (hdr_left)
      3'd4:    hdr_word = sec_q;
      3'd3:    hdr_word = ns_q;
      default: hdr_word = len_q;
    endcase
  end

  // Payload beats come straight from the show-ahead FIFO head, which stays
  // stable until the beat is accepted and popped.
  assign writedata    = (state == DATA_BURST) ? fifo_out : hdr_word;
  assign rd_from_fifo = (state == DATA_BURST) && accept && !empty;
  assign wr_ctrl_rdy  = (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and burst-start strobe.
  always_comb begin
    // NOTE: defaults first so that every path assigns every output and no
    // latch is inferred.
    state_next  = state;
    start_burst = 1'b0;
    case (state)
      IDLE:       if (wr_ctrl) state_next = LATCH;
      LATCH:      state_next = HDR_BURST;
      HDR_BURST: begin
        // write low here is the idle gap before the next header burst.
        if (!write) start_burst = 1'b1;
        if (accept && beats_left == 32'd1 && hdr_left == 3'd1)
          state_next = (data_left == 32'd0) ? DONE : WAIT_DATA;
      end
      WAIT_DATA: begin
        if (data_ready) begin
          start_burst = 1'b1;
          state_next  = DATA_BURST;
        end
      end
      DATA_BURST: begin
        if (accept && beats_left == 32'd1)
          state_next = (data_left == 32'd1) ? DONE : WAIT_DATA;
      end
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Record context, address tracking and Avalon master outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: context registers are reset as well so writedata reads zero
      // while idle after reset, not just the control flops.
      sec_q               <= '0;
      ns_q                <= '0;
      len_q               <= '0;
      buf_start_q         <= '0;
      buf_end_q           <= '0;
      cur_addr            <= '0;
      data_left           <= '0;
      hdr_left            <= '0;
      beats_left          <= '0;
      address             <= '0;
      burstcount          <= '0;
      write               <= 1'b0;
      capt_buf_wrap       <= 1'b0;
      last_write_addr_out <= '0;
    end else begin
      if (state == IDLE && wr_ctrl) begin
        sec_q       <= seconds;
        ns_q        <= nanoseconds;
        len_q       <= len_calc;
        data_left   <= words_calc;
        buf_start_q <= capt_buf_start;
        buf_end_q   <= capt_buf_start + capt_buf_size;
        cur_addr    <= last_write_addr_in;
        hdr_left    <= 3'd4;
      end

      if (start_burst) begin
        address    <= cur_addr;
        burstcount <= burst_len[15:0];
        beats_left <= burst_len;
        write      <= 1'b1;
      end

      if (accept) begin
        cur_addr            <= next_addr;
        last_write_addr_out <= next_addr;
        beats_left          <= beats_left - 32'd1;
        if (wrap_hit) capt_buf_wrap <= 1'b1;
        if (state == HDR_BURST) hdr_left  <= hdr_left - 3'd1;
        else                    data_left <= data_left - 32'd1;
        // Dropping write after the last beat gives the mandatory idle gap.
        if (beats_left == 32'd1) write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_capture_wr_ctrl.sv
// Self-checking bench for capture_wr_ctrl: a queue-based FIFO model and a
// list-based record model predict every burst and every accepted beat.
module tb_capture_wr_ctrl;

  localparam int MAX_BURST = 16;
  localparam int USEDW_W   = 9;

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_ctrl, empty, waitrequest;
  logic [31:0]        control, pkt_begin, pkt_end, capt_buf_start, capt_buf_size;
  logic [31:0]        last_write_addr_in, fifo_out, seconds, nanoseconds;
  logic [USEDW_W-1:0] usedw;
  logic               rd_from_fifo, wr_ctrl_rdy, capt_buf_wrap, write;
  logic [31:0]        last_write_addr_out, address, writedata;
  logic [15:0]        burstcount;

  always #5 clk = ~clk;

  capture_wr_ctrl #(.MAX_BURST(MAX_BURST), .USEDW_W(USEDW_W)) dut (
    .clk(clk), .reset(reset), .wr_ctrl(wr_ctrl), .empty(empty), .control(control),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end), .capt_buf_start(capt_buf_start),
    .capt_buf_size(capt_buf_size), .last_write_addr_in(last_write_addr_in),
    .fifo_out(fifo_out), .rd_from_fifo(rd_from_fifo), .wr_ctrl_rdy(wr_ctrl_rdy),
    .last_write_addr_out(last_write_addr_out), .capt_buf_wrap(capt_buf_wrap),
    .usedw(usedw), .seconds(seconds), .nanoseconds(nanoseconds), .address(address),
    .writedata(writedata), .write(write), .burstcount(burstcount),
    .waitrequest(waitrequest)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // FIFO model: fifo_q is visible to the DUT, hold_q is withheld until released.
  logic [31:0] fifo_q[$];
  logic [31:0] hold_q[$];
  int          pops = 0;
  bit          wrap_model = 1'b0;

  // Expected beats and bursts for the current record.
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_pay[$];
  logic [31:0] exp_baddr[$];
  int          exp_blen[$];
  logic [31:0] exp_last;
  int          exp_words;

  // Bursts as observed on the bus.
  logic [31:0] obs_baddr[$];
  int          obs_blen[$];

  logic [31:0] t1_addr [6];
  int          t1_len  [6];

  task automatic fifo_drive();
    empty    = (fifo_q.size() == 0);
    fifo_out = empty ? 32'h0 : fifo_q[0];
    usedw    = USEDW_W'(fifo_q.size());
  endtask

  // Lay out the record word by word, chunking each phase into bursts that
  // respect the burst limit and the wrap point.
  task automatic build_model(input logic [31:0] b, e, bs, bsz, la, s, ns);
    logic [31:0] len, a, bend, word;
    logic [31:0] src[$];
    int          rem, n, room, idx;
    len       = (e >= b) ? e - b : 32'd0;
    exp_words = int'((len + 32'd3) / 32'd4);
    foreach (fifo_q[i]) src.push_back(fifo_q[i]);
    foreach (hold_q[i]) src.push_back(hold_q[i]);
    a    = la;
    bend = bs + bsz;
    idx  = 0;
    for (int ph = 0; ph < 2; ph++) begin
      rem = (ph == 0) ? 4 : exp_words;
      while (rem > 0) begin
        room = int'((bend - a) / 32'd4);
        n = MAX_BURST;
        if (rem < n)  n = rem;
        if (room < n) n = room;
        exp_baddr.push_back(a);
        exp_blen.push_back(n);
        for (int k = 0; k < n; k++) begin
          if (ph == 0) word = (idx == 0) ? s : (idx == 1) ? ns : len;
          else         word = src[idx-4];
          exp_addr.push_back(a);
          exp_data.push_back(word);
          exp_pay.push_back(ph == 1);
          idx++;
          if (a + 32'd4 == bend) begin
            a = bs;
            wrap_model = 1'b1;
          end else begin
            a = a + 32'd4;
          end
        end
        rem -= n;
      end
    end
    exp_last = a;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   32'(wr_ctrl_rdy), 1);
    check({tag, "_write"}, 32'(write), 0);
    check({tag, "_rd"},    32'(rd_from_fifo), 0);
    check({tag, "_wrap"},  32'(capt_buf_wrap), 0);
    check({tag, "_addr"},  address, 0);
    check({tag, "_wdata"}, writedata, 0);
    check({tag, "_bc"},    32'(burstcount), 0);
    check({tag, "_last"},  last_write_addr_out, 0);
  endtask

  // wmode: 0 no stalls, 1 random stalls, 2 every beat stalled once.
  // release_cyc: cycle at which hold_q is pushed into the FIFO.
  // reset_beat: when >= 0, reset is pulsed once this many beats are accepted.
  task automatic run_record(input logic [31:0] b, e, bs, bsz, la,
                            input int wmode, input int release_cyc, input int reset_beat);
    bit          started, done, prev_write, prev_wait, prev_stall, need_gap, pop_pending;
    logic [31:0] prev_addr, prev_wdata, cur_baddr, s, ns;
    logic [15:0] prev_bc;
    int          cur_blen, beat_in_burst, beats, pops0, cyc;
    started = 0; done = 0; prev_write = 0; prev_wait = 0; prev_stall = 0;
    need_gap = 0; pop_pending = 0; prev_addr = 0; prev_wdata = 0; prev_bc = 0;
    cur_baddr = 0; cur_blen = 0; beat_in_burst = 0; beats = 0; cyc = 0;
    s  = $urandom;
    ns = $urandom;
    build_model(b, e, bs, bsz, la, s, ns);
    pops0 = pops;
    @(negedge clk);
    pkt_begin = b; pkt_end = e; capt_buf_start = bs; capt_buf_size = bsz;
    last_write_addr_in = la; seconds = s; nanoseconds = ns;
    waitrequest = 1'b0;
    wr_ctrl = 1'b1;
    fifo_drive();
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (pop_pending) begin
        fifo_q.delete(0);
        pops++;
        pop_pending = 0;
      end
      if (cyc == release_cyc)
        while (hold_q.size() > 0) fifo_q.push_back(hold_q.pop_front());
      fifo_drive();
      if (wr_ctrl && !wr_ctrl_rdy) begin
        // The record context must already be captured; scramble the inputs.
        started = 1;
        wr_ctrl = 1'b0;
        pkt_begin = $urandom; pkt_end = $urandom; capt_buf_start = $urandom;
        capt_buf_size = $urandom; last_write_addr_in = $urandom;
        seconds = $urandom; nanoseconds = $urandom;
      end
      case (wmode)
        0:       waitrequest = 1'b0;
        1:       waitrequest = 1'($urandom_range(0, 1));
        default: waitrequest = write && !prev_wait;
      endcase
      #1;
      if (reset_beat >= 0 && beats >= reset_beat && write) begin
        #2 reset = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_addr.delete(); exp_data.delete(); exp_pay.delete();
        exp_baddr.delete(); exp_blen.delete(); hold_q.delete(); fifo_q.delete();
        wrap_model = 1'b0;
        fifo_drive();
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (prev_stall) begin
        check("hold_addr",  address, prev_addr);
        check("hold_bc",    32'(burstcount), 32'(prev_bc));
        check("hold_data",  writedata, prev_wdata);
        check("hold_write", 32'(write), 1);
      end
      if (need_gap) begin
        check("burst_gap", 32'(write), 0);
        need_gap = 0;
      end
      if (hold_q.size() > 0 && beats >= 4) begin
        check("starve_write", 32'(write), 0);
        check("starve_rd",    32'(rd_from_fifo), 0);
      end
      if (write && !prev_write) begin
        obs_baddr.push_back(address);
        obs_blen.push_back(int'(burstcount));
        if (exp_baddr.size() == 0) begin
          check("extra_burst", 32'(exp_baddr.size()), 1);
        end else begin
          cur_baddr = exp_baddr.pop_front();
          cur_blen  = exp_blen.pop_front();
          check("burst_addr", address, cur_baddr);
          check("burst_len",  32'(burstcount), 32'(cur_blen));
        end
        beat_in_burst = 0;
      end else if (write) begin
        check("addr_const", address, cur_baddr);
        check("bc_const",   32'(burstcount), 32'(cur_blen));
      end
      if (write && !waitrequest) begin
        if (exp_addr.size() == 0) begin
          check("extra_beat", 32'(exp_addr.size()), 1);
        end else begin
          check("beat_addr", address + 32'(4 * beat_in_burst), exp_addr[0]);
          check("beat_data", writedata, exp_data[0]);
          check("rd_on_beat", 32'(rd_from_fifo), 32'(exp_pay[0]));
          exp_addr.delete(0); exp_data.delete(0); exp_pay.delete(0);
        end
        beats++;
        beat_in_burst++;
        if (beat_in_burst == int'(burstcount)) need_gap = 1;
      end else if (rd_from_fifo) begin
        check("rd_without_beat", 32'(rd_from_fifo), 0);
      end
      if (rd_from_fifo) check("pop_when_empty", 32'(empty), 0);
      pop_pending = rd_from_fifo;
      prev_write = write;
      prev_wait  = waitrequest;
      prev_stall = write && waitrequest;
      prev_addr  = address;
      prev_bc    = burstcount;
      prev_wdata = writedata;
      if (started && wr_ctrl_rdy) done = 1;
    end
    check("record_done", 32'(done), 1);
    if (pop_pending) begin
      fifo_q.delete(0);
      pops++;
    end
    waitrequest = 1'b0;
    fifo_drive();
    check("last_addr",   last_write_addr_out, exp_last);
    check("wrap_flag",   32'(capt_buf_wrap), 32'(wrap_model));
    check("beats_left",  32'(exp_addr.size()), 0);
    check("bursts_left", 32'(exp_baddr.size()), 0);
    check("pop_count",   32'(pops - pops0), 32'(exp_words));
  endtask

  initial begin
    logic [31:0] bs, bsz, la, b, e, len;
    reset = 1'b0;
    wr_ctrl = 1'b0; waitrequest = 1'b0; control = 32'hDEAD_BEEF;
    pkt_begin = 0; pkt_end = 0; capt_buf_start = 0; capt_buf_size = 0;
    last_write_addr_in = 0; seconds = 0; nanoseconds = 0;
    fifo_drive();
    t1_addr = '{32'h8000, 32'h8010, 32'h8050, 32'h8000, 32'h8040, 32'h8000};
    t1_len  = '{4, 16, 12, 16, 16, 1};

    // Reset and idle.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    // Single record that wraps the buffer twice.
    for (int i = 0; i < 244; i++) fifo_q.push_back(32'(10 + i));
    obs_baddr.delete(); obs_blen.delete();
    run_record(32'h0, 32'hF4, 32'h8000, 32'h80, 32'h8000, 0, -1, -1);
    check("t1_nbursts", 32'(obs_baddr.size()), 6);
    for (int i = 0; i < 6 && i < obs_baddr.size(); i++) begin
      check("t1_burst_addr", obs_baddr[i], t1_addr[i]);
      check("t1_burst_len",  32'(obs_blen[i]), 32'(t1_len[i]));
    end
    check("t1_last", last_write_addr_out, 32'h8004);
    check("t1_wrap", 32'(capt_buf_wrap), 1);
    check("t1_rdy",  32'(wr_ctrl_rdy), 1);
    check("t1_fifo_left", 32'(fifo_q.size()), 32'(244 - 61));

    // Every beat stalled once by waitrequest.
    fifo_q.delete();
    for (int i = 0; i < 30; i++) fifo_q.push_back($urandom);
    run_record(32'h20, 32'h95, 32'h3000, 32'h60, 32'h3040, 2, -1, -1);

    // Starved FIFO: 3 words available, 16 needed.
    fifo_q.delete();
    for (int i = 0; i < 3; i++)  fifo_q.push_back($urandom);
    for (int i = 0; i < 13; i++) hold_q.push_back($urandom);
    run_record(32'h0, 32'h40, 32'h4000, 32'h400, 32'h4000, 0, 30, -1);

    // Zero-length record.
    fifo_q.delete();
    fifo_q.push_back(32'h1234_5678);
    run_record(32'h100, 32'h100, 32'h2000, 32'h100, 32'h2000, 2, -1, -1);
    check("zero_last", last_write_addr_out, 32'h2010);
    check("zero_fifo_untouched", 32'(fifo_q.size()), 1);

    // Randomized records with random back-pressure.
    for (int r = 0; r < 8; r++) begin
      bs  = 32'h10000 + 32'(r) * 32'h1000;
      bsz = 32'(4 * $urandom_range(4, 48));
      la  = bs + 32'(4 * $urandom_range(0, int'(bsz / 4) - 1));
      b   = 32'($urandom_range(0, 1000));
      len = 32'($urandom_range(0, 200));
      e   = (r == 3) ? b - 32'd8 : b + len;
      fifo_q.delete();
      for (int i = 0; i < int'((len + 3) / 4) + int'($urandom_range(0, 3)); i++)
        fifo_q.push_back($urandom);
      run_record(b, e, bs, bsz, la, 1, -1, -1);
    end

    // Reset asserted in the middle of a payload burst.
    fifo_q.delete();
    for (int i = 0; i < 40; i++) fifo_q.push_back($urandom);
    run_record(32'h0, 32'hA0, 32'h6000, 32'h200, 32'h6000, 0, -1, 8);
    repeat (2) @(negedge clk);
    check_reset_outputs("after_midrst");

    // Recovery after the abandoned record.
    for (int i = 0; i < 10; i++) fifo_q.push_back($urandom);
    fifo_drive();
    run_record(32'h4, 32'h2C, 32'h7000, 32'h20, 32'h7010, 1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/capture_wr_ctrl.md
Name: capture_wr_ctrl

Overview:
- Packet-capture write controller. It drains one packet's payload words from a show-ahead FIFO and writes a 4-word record header plus the payload to a circular capture buffer in memory.
- Memory writes go through an Avalon-MM burst write master.
- It sits between the packet FIFO/timestamp counter and the memory interconnect, and reports the next free buffer address back to the host-side control logic.

Parameters:
- MAX_BURST, 16, maximum Avalon burst length in words (1..256).
- USEDW_W, 9, width of the FIFO fill-level input.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- wr_ctrl  in  1  start request; level-sampled, accepted only while wr_ctrl_rdy=1.
- empty  in  1  FIFO empty.
- control  in  32  reserved; ignored.
- pkt_begin  in  32  packet start byte offset.
- pkt_end  in  32  packet end byte offset (exclusive).
- capt_buf_start  in  32  capture buffer base byte address (word aligned).
- capt_buf_size  in  32  capture buffer size in bytes (multiple of 4, >= 16).
- last_write_addr_in  in  32  byte address where this record starts.
- fifo_out  in  32  FIFO head word (show-ahead).
- rd_from_fifo  out  1  FIFO pop, one word per cycle asserted.
- wr_ctrl_rdy  out  1  idle / ready for a new record.
- last_write_addr_out  out  32  byte address following the last written word.
- capt_buf_wrap  out  1  sticky: buffer address wrapped at least once.
- usedw  in  USEDW_W  FIFO fill level in words.
- seconds  in  32  timestamp seconds.
- nanoseconds  in  32  timestamp nanoseconds.
- address  out  32  Avalon byte address of the current burst.
- writedata  out  32  Avalon write data.
- write  out  1  Avalon write.
- burstcount  out  16  Avalon burst length in words.
- waitrequest  in  1  Avalon wait request.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ctrl_rdy=1.
  - write=0, rd_from_fifo=0, capt_buf_wrap=0.
  - address, writedata, burstcount and last_write_addr_out = 0.
  - State returns to IDLE; any in-flight burst is abandoned.
- IDLE: when wr_ctrl=1, on the next edge the block:
  - latches pkt_begin, pkt_end, capt_buf_start, capt_buf_size, last_write_addr_in, seconds and nanoseconds;
  - drops wr_ctrl_rdy.
- Length rules:
  - len = pkt_end - pkt_begin when pkt_end >= pkt_begin, else 0.
  - Payload words = ceil(len/4).
- Record layout, written in this order:
  1. seconds
  2. nanoseconds
  3. len
  4. len
  5. payload words in FIFO order.
- Wrap address: end = capt_buf_start + capt_buf_size. The word after end-4 is capt_buf_start, and capt_buf_wrap is set to 1 at that point.
- Burst sizing: each burst length is min(MAX_BURST, words remaining in the current phase, words left before end). Bursts never cross the wrap point.
  - Header phase: at most 4 words; split only at the wrap point.
  - Payload phase: a burst of length n starts only when usedw >= n. Otherwise the block waits in WAIT_DATA with write=0.
- Avalon handshake:
  - A beat is accepted when write=1 and waitrequest=0.
  - While waitrequest=1, address, burstcount and writedata are held stable.
  - address and burstcount stay constant for the whole burst.
  - write stays high between beats of the same burst.
  - write drops for at least one cycle between bursts.
- FIFO pop: rd_from_fifo=1 exactly in the cycles where a payload beat is accepted. writedata must equal fifo_out for that beat. The block never pops when empty=1.
- States: IDLE -> LATCH -> HDR_BURST (repeats if split) -> WAIT_DATA <-> DATA_BURST -> DONE -> IDLE.
  - With 0 payload words, the sequence goes HDR_BURST -> DONE.
- DONE:
  - last_write_addr_out = next word address, already wrapped.
  - wr_ctrl_rdy returns to 1 one cycle later.
  - If wr_ctrl is still high, a new record starts (back-to-back records).
- capt_buf_wrap clears only on reset.

Test Plan:
- Reset, then idle: wr_ctrl_rdy=1, write=0, address=0, capt_buf_wrap=0.
- Single record with wrap:
  - Setup: FIFO prefilled 0xF4 words with values 10..253; pkt_begin=0, pkt_end=0xF4, capt_buf_start=0x8000, size=0x80, last_write_addr_in=0x8000; pulse wr_ctrl.
  - Bursts in order: hdr (0x8000, 4) carrying seconds, ns, 244, 244; (0x8010, 16) first word 10; (0x8050, 12); (0x8000, 16); (0x8040, 16); (0x8000, 1).
  - Afterwards: last_write_addr_out=0x8004, capt_buf_wrap=1, wr_ctrl_rdy=1, 61 FIFO pops.
- Waitrequest back-pressure: waitrequest high on the first cycle of every write -> address, writedata and burstcount stay stable; no data loss or duplication; FIFO pops equal accepted beats.
- Starved FIFO:
  - usedw=3 while the next burst needs 16 -> write=0, rd_from_fifo=0.
  - After usedw reaches 16 -> the burst proceeds.
- Zero-length record: pkt_end=pkt_begin -> 4-word header with len=0; no FIFO pops; last_write_addr_out = start + 16.
- Mid-burst reset: assert reset during DATA_BURST -> all outputs return to reset values immediately; wr_ctrl_rdy=1.
